// File: rtl/snoop_bus_rr.sv
// Snooping coherence bus: round-robin arbitration, snoop broadcast and response collection,
// then the line comes cache-to-cache (dirty owner, also flushed to memory) or from memory.
module snoop_bus_rr #(
  parameter int NUM_CORES     = 4,
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CORES-1:0]                req_valid,
  input  logic [2*NUM_CORES-1:0]              req_op,
  input  logic [NUM_CORES*ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_CORES-1:0]                req_grant,
  output logic                                snoop_valid,
  output logic [1:0]                          snoop_op,
  output logic [ADDRESS_WIDTH-1:0]            snoop_addr,
  output logic [NUM_CORES-1:0]                snoop_src,
  input  logic [NUM_CORES-1:0]                snoop_resp_valid,
  input  logic [NUM_CORES-1:0]                snoop_resp_hit,
  input  logic [NUM_CORES-1:0]                snoop_resp_dirty,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]     snoop_resp_data,
  output logic [NUM_CORES-1:0]                resp_valid,
  output logic [DATA_WIDTH-1:0]               resp_data,
  output logic                                resp_shared,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]               mem_req_data,
  input  logic                                mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]               mem_resp_data,
  output logic [2:0]                          dbg_state
);

  localparam int N  = NUM_CORES;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_RDX  = 2'b01;
  localparam logic [1:0] OP_UPGR = 2'b10;
  localparam logic [1:0] OP_WB   = 2'b11;

  // Memory handshake: mem_req_* hold steady while mem_req_valid is high; the
  // transfer happens on the cycle where mem_req_valid && mem_req_ready.
  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_COLLECT, S_FLUSH, S_MEM_RD, S_MEM_WAIT, S_MEM_WR, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, cur_idx, owner_idx;
  logic [1:0]      cur_op;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata, owner_data, fill_data;
  logic [N-1:0]    responded, src_mask, new_mask, dirty_hit;
  logic            hit_acc, dirty_acc, hit_n, dirty_n, all_resp, new_dirty, is_read;
  logic            hi_found;
  int              hi_idx, lo_idx, win_idx, new_dirty_idx;
  logic [1:0]      win_op;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data, new_dirty_data;

  assign dbg_state = state;
  assign is_read   = (cur_op == OP_RD) || (cur_op == OP_RDX);

  // Winner: first requester at or after rr_ptr, else the lowest requester (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 0;
    lo_idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = i;
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = i;
        end
      end
    end
    win_idx  = hi_found ? hi_idx : lo_idx;
    win_op   = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i == win_idx) begin
        win_op   = req_op[2*i +: 2];
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  // Snoop reply accumulation; repeat strobes and the requester's own strobe are ignored.
  always_comb begin
    for (int i = 0; i < N; i++) src_mask[i] = (i == int'(cur_idx));
    new_mask = '0;
    if (state == S_SNOOP || state == S_COLLECT)
      new_mask = snoop_resp_valid & ~responded & ~src_mask;
    dirty_hit      = new_mask & snoop_resp_dirty;
    hit_n          = hit_acc | (|(new_mask & (snoop_resp_hit | snoop_resp_dirty)));
    new_dirty      = 1'b0;
    new_dirty_idx  = 0;
    new_dirty_data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dirty_hit[i]) begin
        new_dirty      = 1'b1;
        new_dirty_idx  = i;
        new_dirty_data = snoop_resp_data[i*DW +: DW];
      end
    end
    dirty_n  = dirty_acc | new_dirty;
    all_resp = &(responded | new_mask | src_mask);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (|req_valid) state_n = S_SNOOP;
      S_SNOOP:   state_n = S_COLLECT;
      S_COLLECT: begin
        if (all_resp) begin
          if (cur_op == OP_WB)        state_n = S_MEM_WR;
          else if (cur_op == OP_UPGR) state_n = S_DONE;
          else if (dirty_n)           state_n = S_FLUSH;
          else                        state_n = S_MEM_RD;
        end
      end
      S_FLUSH, S_MEM_WR: if (mem_req_ready) state_n = S_DONE;
      S_MEM_RD:   if (mem_req_ready) state_n = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      cur_op     <= '0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      responded  <= '0;
      hit_acc    <= 1'b0;
      dirty_acc  <= 1'b0;
      owner_idx  <= '0;
      owner_data <= '0;
      fill_data  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            cur_idx    <= IW'(win_idx);
            cur_op     <= win_op;
            cur_addr   <= win_addr;
            cur_wdata  <= win_data;
            responded  <= '0;
            hit_acc    <= 1'b0;
            dirty_acc  <= 1'b0;
            owner_data <= '0;
            fill_data  <= '0;
          end
        end
        S_SNOOP, S_COLLECT: begin
          responded <= responded | new_mask;
          hit_acc   <= hit_n;
          dirty_acc <= dirty_n;
          if (new_dirty && (!dirty_acc || new_dirty_idx < int'(owner_idx))) begin
            owner_idx  <= IW'(new_dirty_idx);
            owner_data <= new_dirty_data;
          end
        end
        S_MEM_WAIT: if (mem_resp_valid) fill_data <= mem_resp_data;
        S_DONE:     rr_ptr <= (int'(cur_idx) == N - 1) ? '0 : cur_idx + 1'b1;
        default: ;
      endcase
    end
  end

  // All outputs decode from registers only, so they are 0 while reset is held.
  always_comb begin
    req_grant     = '0;
    snoop_valid   = 1'b0;
    snoop_op      = '0;
    snoop_addr    = '0;
    snoop_src     = '0;
    resp_valid    = '0;
    resp_data     = '0;
    resp_shared   = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (state)
      S_SNOOP: begin
        req_grant   = src_mask;
        snoop_valid = 1'b1;
        snoop_op    = cur_op;
        snoop_addr  = cur_addr;
        snoop_src   = src_mask;
      end
      S_FLUSH: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = cur_addr;
        mem_req_data  = owner_data;
      end
      S_MEM_WR: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = cur_addr;
        mem_req_data  = cur_wdata;
      end
      S_MEM_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = cur_addr;
      end
      S_DONE: begin
        resp_valid  = src_mask;
        resp_shared = hit_acc && (cur_op != OP_WB);
        if (is_read) resp_data = dirty_acc ? owner_data : fill_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snoop_bus_rr.sv
// Directed bench for snoop_bus_rr: behavioural snoopers, requesters and memory around the
// bus, one task per scenario with inline expected-value checks.
module tb_snoop_bus_rr;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_grant;
  logic            snoop_valid;
  logic [1:0]      snoop_op;
  logic [AW-1:0]   snoop_addr;
  logic [N-1:0]    snoop_src;
  logic [N-1:0]    snoop_resp_valid, snoop_resp_hit, snoop_resp_dirty;
  logic [N*DW-1:0] snoop_resp_data;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic            resp_shared;
  logic            mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;
  logic [2:0]      dbg_state;

  snoop_bus_rr #(.NUM_CORES(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .req_grant(req_grant),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .snoop_resp_valid(snoop_resp_valid), .snoop_resp_hit(snoop_resp_hit),
    .snoop_resp_dirty(snoop_resp_dirty), .snoop_resp_data(snoop_resp_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_shared(resp_shared),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic all_out_nz;
  assign all_out_nz = |{req_grant, snoop_valid, snoop_op, snoop_addr, snoop_src, resp_valid,
                        resp_data, resp_shared, mem_req_valid, mem_req_write, mem_req_addr,
                        mem_req_data};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ---------------- environment configuration and logs ----------------
  int           snp_delay[N];
  logic [N-1:0] snp_hit_cfg, snp_dirty_cfg;
  logic [DW-1:0] snp_data_cfg[N];
  int           mem_stall_cfg, mem_extra_cfg;
  logic [DW-1:0] mem_rd_cfg;
  logic [N-1:0] keep_req;

  int            mem_rd_cnt, mem_wr_cnt, mem_valid_cycles, mem_unstable;
  logic [AW-1:0] mem_last_rd_addr, mem_last_wr_addr;
  logic [DW-1:0] mem_last_wr_data;

  typedef struct {
    logic [N-1:0]  mask;
    logic [DW-1:0] data;
    logic          shared;
    int            cyc;
  } resp_t;
  resp_t      resp_q[$];
  resp_t      mon_r;
  logic [1:0] grant_q[$];
  logic [1:0] exp_q[$];
  int         grant_cyc;
  logic       sn_valid;
  logic [1:0] sn_op;
  logic [AW-1:0] sn_addr;
  logic [N-1:0]  sn_src;

  // ---------------- monitor and requesters ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (req_grant[i]) begin
          grant_q.push_back(2'(i));
          grant_cyc = cyc;
          sn_valid  = snoop_valid;
          sn_op     = snoop_op;
          sn_addr   = snoop_addr;
          sn_src    = snoop_src;
          if (!keep_req[i]) req_valid[i] = 1'b0;
        end
      end
      if (|resp_valid) begin
        mon_r.mask   = resp_valid;
        mon_r.data   = resp_data;
        mon_r.shared = resp_shared;
        mon_r.cyc    = cyc;
        resp_q.push_back(mon_r);
      end
    end
  end

  // ---------------- snoopers ----------------
  logic [N-1:0] pend;
  int           pend_cnt[N];
  initial begin
    pend = '0;
    forever begin
      @(negedge clk);
      snoop_resp_valid = '0;
      snoop_resp_hit   = '0;
      snoop_resp_dirty = '0;
      snoop_resp_data  = '0;
      if (reset) pend = '0;
      else begin
        if (snoop_valid) begin
          for (int i = 0; i < N; i++) begin
            if (!snoop_src[i]) begin
              pend[i]     = 1'b1;
              pend_cnt[i] = snp_delay[i];
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if (pend[i]) begin
            if (pend_cnt[i] == 0) begin
              snoop_resp_valid[i]         = 1'b1;
              snoop_resp_hit[i]           = snp_hit_cfg[i];
              snoop_resp_dirty[i]         = snp_dirty_cfg[i];
              snoop_resp_data[i*DW +: DW] = snp_data_cfg[i];
              pend[i]                     = 1'b0;
            end else pend_cnt[i]--;
          end
        end
      end
    end
  end

  // ---------------- memory ----------------
  logic          in_req, rd_pend, first_w;
  int            stall_left, rd_cnt;
  logic [AW-1:0] first_a;
  logic [DW-1:0] first_d;
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    in_req = 1'b0; rd_pend = 1'b0; rd_cnt = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_rd_cfg;
          rd_pend        = 1'b0;
        end else rd_cnt--;
      end
      mem_req_ready = 1'b0;
      if (!mem_req_valid) in_req = 1'b0;
      else begin
        if (!in_req) begin
          in_req = 1'b1; stall_left = mem_stall_cfg; mem_valid_cycles = 0;
          first_w = mem_req_write; first_a = mem_req_addr; first_d = mem_req_data;
        end
        mem_valid_cycles++;
        if (mem_req_write !== first_w || mem_req_addr !== first_a || mem_req_data !== first_d)
          mem_unstable++;
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready = 1'b1;
          in_req = 1'b0;
          if (mem_req_write) begin
            mem_wr_cnt++; mem_last_wr_addr = mem_req_addr; mem_last_wr_data = mem_req_data;
          end else begin
            mem_rd_cnt++; mem_last_rd_addr = mem_req_addr;
            rd_pend = 1'b1; rd_cnt = mem_extra_cfg;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int core, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_op[2*core +: 2]   = op;
    req_addr[core*AW +: AW] = a;
    req_data[core*DW +: DW] = d;
    req_valid[core]       = 1'b1;
  endtask

  task automatic set_snoop(input int d0, input int d1, input int d2, input int d3,
                           input logic [N-1:0] hit, input logic [N-1:0] dirty);
    snp_delay[0] = d0; snp_delay[1] = d1; snp_delay[2] = d2; snp_delay[3] = d3;
    snp_hit_cfg = hit; snp_dirty_cfg = dirty;
  endtask

  task automatic clear_logs();
    resp_q.delete(); grant_q.delete(); exp_q.delete();
    mem_rd_cnt = 0; mem_wr_cnt = 0; mem_unstable = 0; mem_valid_cycles = 0;
  endtask

  task automatic wait_resp(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (resp_q.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (dbg_state == 3'd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0;
    keep_req  = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    clear_logs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (all_out_nz !== 1'b0) begin failures++; $display("FAIL reset_outputs: got %b want 0", all_out_nz); end
    checks++;
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
    repeat (3) @(negedge clk); #1;
    checks++;
    if (all_out_nz !== 1'b0) begin failures++; $display("FAIL idle_outputs: got %b want 0", all_out_nz); end
    checks++;
    if (dbg_state !== 3'd0) begin failures++; $display("FAIL idle_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_mem_read();
    bit ok;
    clear_logs();
    set_snoop(1, 1, 1, 1, 4'b0000, 4'b0000);
    mem_stall_cfg = 0; mem_extra_cfg = 0; mem_rd_cfg = 32'hDEADBEEF;
    @(negedge clk); #1;
    issue(2, 2'b00, 6'h0A, '0);
    wait_resp(60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t1_timeout: got none want resp"); return; end
    checks++;
    if (sn_valid !== 1'b1 || sn_src !== 4'b0100 || sn_addr !== 6'h0A || sn_op !== 2'b00) begin
      failures++;
      $display("FAIL t1_snoop: got v=%b src=%b addr=%h op=%b want 1 0100 0a 00", sn_valid, sn_src, sn_addr, sn_op);
    end
    checks++;
    if (resp_q[0].mask !== 4'b0100) begin failures++; $display("FAIL t1_resp_mask: got %b want 0100", resp_q[0].mask); end
    checks++;
    if (resp_q[0].data !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_resp_data: got %h want deadbeef", resp_q[0].data); end
    checks++;
    if (resp_q[0].shared !== 1'b0) begin failures++; $display("FAIL t1_shared: got %b want 0", resp_q[0].shared); end
    checks++;
    if (mem_rd_cnt != 1 || mem_wr_cnt != 0) begin failures++; $display("FAIL t1_mem_count: got rd=%0d wr=%0d want 1 0", mem_rd_cnt, mem_wr_cnt); end
    checks++;
    if (mem_last_rd_addr !== 6'h0A) begin failures++; $display("FAIL t1_mem_addr: got %h want 0a", mem_last_rd_addr); end
  endtask

  task automatic test_dirty_flush();
    bit ok;
    clear_logs();
    set_snoop(1, 1, 1, 1, 4'b1000, 4'b1000);
    snp_data_cfg[3] = 32'h1234;
    @(negedge clk); #1;
    issue(0, 2'b00, 6'h05, '0);
    wait_resp(60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t2_timeout: got none want resp"); return; end
    checks++;
    if (resp_q[0].mask !== 4'b0001) begin failures++; $display("FAIL t2_resp_mask: got %b want 0001", resp_q[0].mask); end
    checks++;
    if (resp_q[0].data !== 32'h1234) begin failures++; $display("FAIL t2_resp_data: got %h want 1234", resp_q[0].data); end
    checks++;
    if (resp_q[0].shared !== 1'b1) begin failures++; $display("FAIL t2_shared: got %b want 1", resp_q[0].shared); end
    checks++;
    if (mem_rd_cnt != 0 || mem_wr_cnt != 1) begin failures++; $display("FAIL t2_mem_count: got rd=%0d wr=%0d want 0 1", mem_rd_cnt, mem_wr_cnt); end
    checks++;
    if (mem_last_wr_addr !== 6'h05 || mem_last_wr_data !== 32'h1234) begin
      failures++; $display("FAIL t2_flush: got %h/%h want 05/1234", mem_last_wr_addr, mem_last_wr_data);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    set_snoop(0, 0, 0, 0, 4'b0000, 4'b0000);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    @(negedge clk); #1;
    keep_req = 4'b1011;
    issue(0, 2'b10, 6'h01, '0);
    issue(1, 2'b10, 6'h02, '0);
    issue(3, 2'b10, 6'h03, '0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (grant_q.size() >= 6) begin ok = 1'b1; break; end
    end
    req_valid = '0;
    keep_req  = '0;
    checks++;
    if (!ok) begin failures++; $display("FAIL t3_timeout: got %0d grants want 6", grant_q.size()); return; end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (grant_q[k] !== exp_q[k]) begin failures++; $display("FAIL t3_grant_order[%0d]: got %0d want %0d", k, grant_q[k], exp_q[k]); end
    end
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (grant_q[k] === grant_q[k-1]) begin failures++; $display("FAIL t3_repeat[%0d]: got %0d twice want change", k, grant_q[k]); end
    end
    wait_idle(20, ok);
  endtask

  task automatic test_wb_stall();
    bit ok;
    clear_logs();
    set_snoop(1, 1, 1, 1, 4'b0001, 4'b0000);
    mem_stall_cfg = 3;
    @(negedge clk); #1;
    issue(1, 2'b11, 6'h3F, 32'hA5A5);
    wait_resp(60, ok);
    mem_stall_cfg = 0;
    checks++;
    if (!ok) begin failures++; $display("FAIL t4_timeout: got none want resp"); return; end
    checks++;
    if (mem_valid_cycles != 4) begin failures++; $display("FAIL t4_valid_cycles: got %0d want 4", mem_valid_cycles); end
    checks++;
    if (mem_unstable != 0) begin failures++; $display("FAIL t4_stable: got %0d changes want 0", mem_unstable); end
    checks++;
    if (mem_wr_cnt != 1 || mem_rd_cnt != 0 || mem_last_wr_addr !== 6'h3F || mem_last_wr_data !== 32'hA5A5) begin
      failures++;
      $display("FAIL t4_write: got wr=%0d rd=%0d %h/%h want 1 0 3f/a5a5", mem_wr_cnt, mem_rd_cnt, mem_last_wr_addr, mem_last_wr_data);
    end
    checks++;
    if (resp_q[0].mask !== 4'b0010) begin failures++; $display("FAIL t4_resp_mask: got %b want 0010", resp_q[0].mask); end
    checks++;
    if (resp_q[0].data !== 32'h0 || resp_q[0].shared !== 1'b0) begin
      failures++; $display("FAIL t4_resp_fields: got %h/%b want 0/0", resp_q[0].data, resp_q[0].shared);
    end
    wait_idle(20, ok);
  endtask

  task automatic test_upgr_delays();
    bit ok;
    clear_logs();
    set_snoop(0, 2, 6, 0, 4'b0010, 4'b0000);
    @(negedge clk); #1;
    issue(3, 2'b10, 6'h11, '0);
    wait_resp(60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t5_timeout: got none want resp"); return; end
    checks++;
    if (resp_q[0].cyc - grant_cyc != 7) begin failures++; $display("FAIL t5_latency: got %0d want 7", resp_q[0].cyc - grant_cyc); end
    checks++;
    if (resp_q[0].mask !== 4'b1000) begin failures++; $display("FAIL t5_resp_mask: got %b want 1000", resp_q[0].mask); end
    checks++;
    if (resp_q[0].data !== 32'h0 || resp_q[0].shared !== 1'b1) begin
      failures++; $display("FAIL t5_resp_fields: got %h/%b want 0/1", resp_q[0].data, resp_q[0].shared);
    end
    checks++;
    if (mem_rd_cnt != 0 || mem_wr_cnt != 0) begin failures++; $display("FAIL t5_no_mem: got rd=%0d wr=%0d want 0 0", mem_rd_cnt, mem_wr_cnt); end
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    set_snoop(1, 1, 1, 1, 4'b0000, 4'b0000);
    mem_extra_cfg = 6; mem_rd_cfg = 32'hBAD0BAD0;
    @(negedge clk); #1;
    issue(0, 2'b00, 6'h22, '0);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (dbg_state == 3'd5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL t6_reach_wait: got state %0d want 5", dbg_state); return; end
    reset = 1'b1;
    #1;
    checks++;
    if (all_out_nz !== 1'b0 || dbg_state !== 3'd0) begin
      failures++; $display("FAIL t6_async_reset: got out=%b state=%0d want 0 0", all_out_nz, dbg_state);
    end
    @(negedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (resp_q.size() != 0 || dbg_state !== 3'd0) begin
      failures++; $display("FAIL t6_late_mem: got resps=%0d state=%0d want 0 0", resp_q.size(), dbg_state);
    end
    clear_logs();
    mem_extra_cfg = 0; mem_rd_cfg = 32'h13572468;
    issue(2, 2'b00, 6'h2B, '0);
    wait_resp(60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t6_timeout: got none want resp"); return; end
    checks++;
    if (grant_q.size() != 1 || grant_q[0] !== 2'd2) begin failures++; $display("FAIL t6_grant: got %0d grants want one to core 2", grant_q.size()); end
    checks++;
    if (resp_q[0].mask !== 4'b0100 || resp_q[0].data !== 32'h13572468) begin
      failures++; $display("FAIL t6_resp: got %b/%h want 0100/13572468", resp_q[0].mask, resp_q[0].data);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    req_valid = '0; req_op = '0; req_addr = '0; req_data = '0;
    keep_req = '0;
    for (int i = 0; i < N; i++) begin snp_delay[i] = 1; snp_data_cfg[i] = '0; end
    snp_hit_cfg = '0; snp_dirty_cfg = '0;
    mem_stall_cfg = 0; mem_extra_cfg = 0; mem_rd_cfg = '0;
    clear_logs();
    test_reset();
    test_mem_read();
    test_dirty_flush();
    test_back_to_back();
    test_wb_stall();
    test_upgr_delays();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
